// File: rtl/mult_display_sequencer_if.sv
// Signal bundle between the multiply/display sequencer and its start button,
// operand switches, multiplier, sign-magnitude stage, BCD stage and display.
interface mult_display_sequencer_if;
  // Every valid/ready (valid/done) pair: valid rises on stage entry and holds
  // until ready is sampled high on a rising edge; data moves on that edge and
  // valid is low the next cycle. Ready seen while valid is low is ignored.
  logic        start;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic        mult_valid;
  logic [7:0]  mult_a;
  logic [7:0]  mult_b;
  logic        mult_done;
  logic [15:0] mult_result;
  logic        sm_valid;
  logic [15:0] sm_operand;
  logic        sm_ready;
  logic [15:0] magnitud;
  logic        sign;
  logic        bcd_valid;
  logic [15:0] bcd_operand;
  logic        bcd_ready;
  logic [15:0] bcd_code;
  logic        disp_load;
  logic [15:0] disp_bcd;
  logic        disp_sign;
  logic        disp_overflow;
  logic        busy;
  logic        error;

  modport master (
    input  start, operand_a, operand_b, mult_done, mult_result, sm_ready,
           magnitud, sign, bcd_ready, bcd_code,
    output mult_valid, mult_a, mult_b, sm_valid, sm_operand, bcd_valid,
           bcd_operand, disp_load, disp_bcd, disp_sign, disp_overflow, busy, error
  );

  modport slave (
    output start, operand_a, operand_b, mult_done, mult_result, sm_ready,
           magnitud, sign, bcd_ready, bcd_code,
    input  mult_valid, mult_a, mult_b, sm_valid, sm_operand, bcd_valid,
           bcd_operand, disp_load, disp_bcd, disp_sign, disp_overflow, busy, error
  );
endinterface

// File: rtl/mult_display_sequencer.sv
// Sequences one signed 8x8 multiply through multiplier, sign-magnitude and BCD
// stages, then loads the display; any stage that stalls past TIMEOUT aborts.
module mult_display_sequencer #(
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  mult_display_sequencer_if.master bus,
  output logic [2:0]               o_dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_SIGN = 3'd2,
    S_BCD  = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam int              TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TLAST     = TW'(TIMEOUT - 1);
  localparam logic [15:0]     MAX_SHOWN = 16'd9999;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_sign;

  logic w_in_stage;
  logic w_stage_ack;
  logic w_abort;

  // Ready only counts while the matching valid is up.
  always_comb begin
    w_stage_ack = 1'b0;
    case (r_state)
      S_MULT:  w_stage_ack = bus.mult_valid & bus.mult_done;
      S_SIGN:  w_stage_ack = bus.sm_valid & bus.sm_ready;
      S_BCD:   w_stage_ack = bus.bcd_valid & bus.bcd_ready;
      default: w_stage_ack = 1'b0;
    endcase
  end

  assign w_in_stage  = (r_state == S_MULT) || (r_state == S_SIGN) || (r_state == S_BCD);
  assign w_abort     = w_in_stage && (r_timer == TLAST) && !w_stage_ack;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_timer           <= '0;
      r_sign            <= 1'b0;
      bus.mult_valid    <= 1'b0;
      bus.mult_a        <= '0;
      bus.mult_b        <= '0;
      bus.sm_valid      <= 1'b0;
      bus.sm_operand    <= '0;
      bus.bcd_valid     <= 1'b0;
      bus.bcd_operand   <= '0;
      bus.disp_load     <= 1'b0;
      bus.disp_bcd      <= '0;
      bus.disp_sign     <= 1'b0;
      bus.disp_overflow <= 1'b0;
      bus.busy          <= 1'b0;
      bus.error         <= 1'b0;
    end else begin
      bus.disp_load <= 1'b0;
      case (r_state)
        S_IDLE, S_SHOW, S_ERR: begin
          if (bus.start) begin
            bus.mult_a     <= bus.operand_a;
            bus.mult_b     <= bus.operand_b;
            bus.mult_valid <= 1'b1;
            bus.busy       <= 1'b1;
            bus.error      <= 1'b0;
            r_timer        <= '0;
            r_state        <= S_MULT;
          end
        end
        S_MULT: begin
          if (w_stage_ack) begin
            bus.sm_operand <= bus.mult_result;
            bus.mult_valid <= 1'b0;
            bus.sm_valid   <= 1'b1;
            r_timer        <= '0;
            r_state        <= S_SIGN;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_SIGN: begin
          if (w_stage_ack) begin
            bus.sm_valid <= 1'b0;
            r_timer      <= '0;
            if (bus.magnitud > MAX_SHOWN) begin
              // Too wide for four digits: show the overflow pattern directly.
              bus.disp_bcd      <= 16'hFFFF;
              bus.disp_overflow <= 1'b1;
              bus.disp_sign     <= bus.sign;
              bus.disp_load     <= 1'b1;
              bus.busy          <= 1'b0;
              r_state           <= S_SHOW;
            end else begin
              bus.bcd_operand <= bus.magnitud;
              bus.bcd_valid   <= 1'b1;
              r_sign          <= bus.sign & (bus.magnitud != 16'd0);
              r_state         <= S_BCD;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_BCD: begin
          if (w_stage_ack) begin
            bus.bcd_valid     <= 1'b0;
            bus.disp_bcd      <= bus.bcd_code;
            bus.disp_overflow <= 1'b0;
            bus.disp_sign     <= r_sign;
            bus.disp_load     <= 1'b1;
            bus.busy          <= 1'b0;
            r_timer           <= '0;
            r_state           <= S_SHOW;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Stall abort overrides the per-state updates above.
      if (w_abort) begin
        bus.mult_valid <= 1'b0;
        bus.sm_valid   <= 1'b0;
        bus.bcd_valid  <= 1'b0;
        bus.busy       <= 1'b0;
        bus.error      <= 1'b1;
        r_timer        <= '0;
        r_state        <= S_ERR;
      end
    end
  end
endmodule

// File: tb/tb_mult_display_sequencer.sv
// Randomized bench for mult_display_sequencer: behavioural responders for the
// three stages, a display scoreboard and directed boundary/reset scenarios.
module tb_mult_display_sequencer;
  localparam int TIMEOUT = 16;
  localparam int BUDGET  = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  mult_display_sequencer_if bus();

  mult_display_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int          n_chk = 0;
  int          n_err = 0;
  logic [17:0] exp_q[$];
  logic [17:0] g_disp;
  int          d_m, d_s, d_b;
  int          c_m, c_s, c_b;
  int          load_cnt, viol;
  bit          bcd_seen;
  bit          force_rdy;
  logic        pv_m, pr_m, pv_s, pr_s, pv_b, pr_b;
  logic        p_rst = 1'b1;
  logic [17:0] p_disp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int rand_delay();
    int r;
    r = $urandom_range(0, 15);
    if (r < 13) return $urandom_range(0, 4);
    return (r == 13) ? TIMEOUT - 1 : TIMEOUT;
  endfunction

  // ---------------- responders + monitor (negedge) ----------------
  always @(negedge clk) begin
    int prod, sv;
    logic [17:0] disp_now;
    disp_now = {bus.disp_overflow, bus.disp_sign, bus.disp_bcd};
    if (bus.disp_load === 1'b1) begin
      load_cnt++;
      if (exp_q.size() == 0) chk("extra_load", 1, 0);
      else                   chk("disp_word", disp_now, exp_q.pop_front());
    end
    if (!p_rst) begin
      if (pv_m && !pr_m && !bus.mult_valid && !bus.error) viol++;
      if (pv_s && !pr_s && !bus.sm_valid   && !bus.error) viol++;
      if (pv_b && !pr_b && !bus.bcd_valid  && !bus.error) viol++;
      if (pv_m && pr_m && bus.mult_valid) viol++;
      if (pv_s && pr_s && bus.sm_valid)   viol++;
      if (pv_b && pr_b && bus.bcd_valid)  viol++;
      if (bus.disp_load !== 1'b1 && disp_now !== p_disp) viol++;
    end
    if (bus.bcd_valid === 1'b1) bcd_seen = 1'b1;

    // multiplier
    if (bus.mult_valid === 1'b1) begin
      bus.mult_done = (c_m >= d_m);
      c_m++;
      prod = int'($signed(bus.mult_a)) * int'($signed(bus.mult_b));
      bus.mult_result = bus.mult_done ? prod[15:0] : 16'($urandom);
    end else begin
      c_m = 0;
      bus.mult_done   = force_rdy || ($urandom_range(0, 3) == 0);
      bus.mult_result = 16'($urandom);
    end
    // sign-magnitude stage; reports a zero as negative on purpose
    if (bus.sm_valid === 1'b1) begin
      bus.sm_ready = (c_s >= d_s);
      c_s++;
      sv = int'($signed(bus.sm_operand));
      if (bus.sm_ready) begin
        bus.magnitud = (sv < 0) ? 16'(-sv) : 16'(sv);
        bus.sign     = (sv <= 0);
      end else begin
        bus.magnitud = 16'($urandom);
        bus.sign     = 1'($urandom);
      end
    end else begin
      c_s = 0;
      bus.sm_ready = force_rdy || ($urandom_range(0, 3) == 0);
      bus.magnitud = 16'($urandom);
      bus.sign     = 1'($urandom);
    end
    // BCD stage
    if (bus.bcd_valid === 1'b1) begin
      bus.bcd_ready = (c_b >= d_b);
      c_b++;
      bus.bcd_code  = bus.bcd_ready ? to_bcd(int'(bus.bcd_operand)) : 16'($urandom);
    end else begin
      c_b = 0;
      bus.bcd_ready = force_rdy || ($urandom_range(0, 3) == 0);
      bus.bcd_code  = 16'($urandom);
    end

    pv_m = bus.mult_valid; pr_m = bus.mult_done;
    pv_s = bus.sm_valid;   pr_s = bus.sm_ready;
    pv_b = bus.bcd_valid;  pr_b = bus.bcd_ready;
    p_disp = disp_now;
    p_rst  = rst;
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_state(input string tag);
    chk({tag, "_valids"}, {bus.mult_valid, bus.sm_valid, bus.bcd_valid}, 0);
    chk({tag, "_load"},   bus.disp_load, 0);
    chk({tag, "_disp"},   {bus.disp_overflow, bus.disp_sign, bus.disp_bcd}, 0);
    chk({tag, "_busy"},   bus.busy, 0);
    chk({tag, "_error"},  bus.error, 0);
    chk({tag, "_ops"},    {bus.mult_a, bus.mult_b}, 0);
    chk({tag, "_stage_ops"}, {bus.sm_operand, bus.bcd_operand}, 0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int dm, input int ds, input int db, input int glitch);
    int p, mag, cyc, lat_exp, err_cyc;
    bit ovf, to_err, reach_bcd;
    logic [17:0] exp_word;
    p   = int'($signed(a)) * int'($signed(b));
    mag = (p < 0) ? -p : p;
    ovf = (mag > 9999);
    to_err = 0; reach_bcd = 0; lat_exp = 0; err_cyc = 0;
    if (dm >= TIMEOUT) begin
      to_err = 1; err_cyc = TIMEOUT;
    end else if (ds >= TIMEOUT) begin
      to_err = 1; err_cyc = dm + 1 + TIMEOUT;
    end else if (ovf) begin
      lat_exp = 1 + (dm + 1) + (ds + 1);
    end else begin
      reach_bcd = 1;
      if (db >= TIMEOUT) begin
        to_err = 1; err_cyc = dm + ds + 2 + TIMEOUT;
      end else begin
        lat_exp = 1 + (dm + 1) + (ds + 1) + (db + 1);
      end
    end
    exp_word = {ovf, (p < 0), ovf ? 16'hFFFF : to_bcd(mag)};
    if (!to_err) begin
      exp_q.push_back(exp_word);
      g_disp = exp_word;
    end
    d_m = dm; d_s = ds; d_b = db;
    load_cnt = 0; viol = 0; bcd_seen = 0;

    @(negedge clk);
    bus.start = 1'b1; bus.operand_a = a; bus.operand_b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.operand_a = 8'($urandom); bus.operand_b = 8'($urandom);
    chk("busy_on_start", bus.busy, 1);
    chk("error_cleared", bus.error, 0);
    chk("mult_valid_up", bus.mult_valid, 1);
    cyc = 0;
    while (bus.disp_load !== 1'b1 && bus.error !== 1'b1 && cyc < BUDGET) begin
      bus.start = (cyc == glitch);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("done_wait", (cyc < BUDGET), 1);
    if (to_err) begin
      chk("err_flag", bus.error, 1);
      chk("err_latency", cyc, err_cyc);
    end else begin
      chk("load_flag", bus.disp_load, 1);
      chk("latency", cyc + 1, lat_exp);
    end
    repeat (3) @(negedge clk);
    chk("load_count", load_cnt, to_err ? 0 : 1);
    chk("bcd_requested", bcd_seen, reach_bcd);
    chk("display", {bus.disp_overflow, bus.disp_sign, bus.disp_bcd}, g_disp);
    chk("error_hold", bus.error, to_err);
    chk("busy_after", bus.busy, 0);
    chk("valids_low", {bus.mult_valid, bus.sm_valid, bus.bcd_valid}, 0);
    chk("operands", {bus.mult_a, bus.mult_b}, {a, b});
    chk("protocol", viol, 0);
  endtask

  task automatic reset_mid_bcd();
    int cyc;
    d_m = 0; d_s = 0; d_b = 6; load_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.operand_a = 8'd25; bus.operand_b = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.bcd_valid !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("bcd_reached", bus.bcd_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 force_rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 force_rdy = 1'b0;
    g_disp = '0;
    @(negedge clk);
    check_reset_state("rst_mid");
    repeat (4) @(negedge clk);
    chk("rst_mid_idle", bus.busy, 0);
    chk("rst_mid_noload", load_cnt, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; force_rdy = 1'b0; g_disp = '0;
    bus.start = 1'b0; bus.operand_a = '0; bus.operand_b = '0;
    d_m = 0; d_s = 0; d_b = 0; load_cnt = 0; viol = 0; bcd_seen = 0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    run_op(8'd12,   -8'sd3,  0, 0, 0, -1);              // -36, zero wait
    run_op(8'd127,  8'd127,  0, 0, 0, -1);              // overflow path
    run_op(8'd99,   8'd101,  1, 0, 2, -1);              // 9999 still shown
    run_op(8'd100,  8'd100,  0, 1, 0, -1);              // 10000 overflows
    run_op(8'h80,   8'h80,   1, 2, 3, -1);              // +16384
    run_op(8'h80,   8'd127,  2, 0, 0, -1);              // negative overflow
    run_op(8'd5,    8'd5,    0, TIMEOUT, 0, -1);        // stall in SIGN
    run_op(8'd7,    -8'sd9,  0, 0, 0, -1);              // start clears error
    run_op(8'd3,    8'd3,    TIMEOUT-1, TIMEOUT-1, TIMEOUT-1, -1);
    run_op(8'd1,    8'd1,    TIMEOUT, 0, 0, -1);        // stall in MULT
    run_op(8'd20,   8'd20,   0, 0, TIMEOUT, -1);        // stall in BCD
    run_op(8'd0,    -8'sd7,  5, 5, 5, 8);               // start during SIGN

    // ready strobes with nothing requested
    load_cnt = 0;
    @(negedge clk); force_rdy = 1'b1;
    repeat (4) @(negedge clk);
    force_rdy = 1'b0;
    @(negedge clk);
    chk("idle_noload", load_cnt, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_disp", {bus.disp_overflow, bus.disp_sign, bus.disp_bcd}, g_disp);

    for (int i = 0; i < 40; i++)
      run_op(8'($urandom), 8'($urandom), rand_delay(), rand_delay(), rand_delay(), -1);

    run_op(8'd45, 8'd2, 0, 0, 0, -1);
    reset_mid_bcd();

    // reset and start on the same edge
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.operand_a = 8'd55; bus.operand_b = 8'd66;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("rst_start");

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
